mips_mc_control: RTL and testbench

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

---
 rtl/mips_mc_pkg.sv | 40 ++++
 rtl/mips_mc_control.sv | 169 ++++++++++++++++
 tb/tb_mips_mc_control.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared opcode, state and datapath-select encodings for the multicycle MIPS control
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BEQEX  = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JEX    = 4'd11
  } state_t;

  // ALUOp is also decoded by the ALU control stage
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_RT    = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - Moore control FSM for the multicycle MIPS datapath
// Define MC_JUMP_EN to include the JEX (j instruction) state; otherwise opcode 000010 is illegal.
module mips_mc_control
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d       = FETCH;
    illegal_d     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_RT;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = ALUB_FOUR;
        alu_op    = ALUOP_ADD;
        pc_write  = 1'b1;
        pc_source = PCSRC_ALU;
        state_d   = DECODE;
      end
      DECODE: begin
        alu_src_a = 1'b0;
        alu_src_b = ALUB_IMMSH;
        alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         state_d = JEX;
`endif
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = FETCH;
      end
      RTEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_RT;
        alu_op    = ALUOP_FUNCT;
        state_d   = RTWB;
      end
      RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BEQEX: begin
        alu_src_a     = 1'b1;
        alu_src_b     = ALUB_RT;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
`ifdef MC_JUMP_EN
      JEX: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = FETCH;
      end
`endif
      // unused codes (and JEX when jumps are disabled) recover to FETCH
      default: begin
        state_d   = FETCH;
        illegal_d = 1'b1;
      end
    endcase
  end

  // reset holds every strobe and select low, not just the state register
  assign PCWrite     = rst_n & pc_write;
  assign PCWriteCond = rst_n & pc_write_cond;
  assign IorD        = rst_n & iord;
  assign MemRead     = rst_n & mem_read;
  assign MemWrite    = rst_n & mem_write;
  assign IRWrite     = rst_n & ir_write;
  assign MemtoReg    = rst_n & mem_to_reg;
  assign RegDst      = rst_n & reg_dst;
  assign RegWrite    = rst_n & reg_write;
  assign ALUSrcA     = rst_n & alu_src_a;
  assign ALUSrcB     = {2{rst_n}} & alu_src_b;
  assign PCSource    = {2{rst_n}} & pc_source;
  assign ALUOp       = {2{rst_n}} & alu_op;
  assign illegal_op  = illegal_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - directed self-checking bench for mips_mc_control
`timescale 1ns/1ps
module tb_mips_mc_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] state;

  int checks;
  int failures;

  mips_mc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSource   (PCSource),
    .ALUOp      (ALUOp),
    .illegal_op (illegal_op),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] all_outs();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op};
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    opcode = 6'b000000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", state);
    end
    checks++;
    if (all_outs() !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0000", all_outs());
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({state, MemRead, IRWrite, PCWrite, ALUSrcB, ALUOp, PCSource, illegal_op} !== {4'd0, 3'b111, 2'b01, 2'b00, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL reset_release_fetch got=%h exp=%h",
               {state, MemRead, IRWrite, PCWrite, ALUSrcB, ALUOp, PCSource, illegal_op},
               {4'd0, 3'b111, 2'b01, 2'b00, 2'b00, 1'b0});
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd1 || ALUSrcB !== 2'b11 || ALUSrcA !== 1'b0 || IRWrite !== 1'b0) begin
      failures++;
      $display("FAIL decode_outputs got state=%0d srcb=%b srca=%b ir=%b exp state=1 srcb=11 srca=0 ir=0",
               state, ALUSrcB, ALUSrcA, IRWrite);
    end
    // opcode 000000 is R-type: finish that instruction to land back in FETCH
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_lw();
    int exp_st[6] = '{0, 1, 2, 3, 4, 0};
    opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (state !== exp_st[i][3:0] || RegWrite !== (exp_st[i] == 4) || MemtoReg !== (exp_st[i] == 4)) begin
        failures++;
        $display("FAIL lw_step%0d got state=%0d regwr=%b m2r=%b exp state=%0d regwr=m2r=%b",
                 i, state, RegWrite, MemtoReg, exp_st[i], exp_st[i] == 4);
      end
      if (i < 5) @(negedge clk);
    end
  endtask

  task automatic test_sw();
    int exp_st[5] = '{0, 1, 2, 5, 0};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== exp_st[i][3:0] || MemWrite !== (exp_st[i] == 5) || IorD !== (exp_st[i] == 5) || RegWrite !== 1'b0) begin
        failures++;
        $display("FAIL sw_step%0d got state=%0d memwr=%b iord=%b regwr=%b exp state=%0d memwr=iord=%b regwr=0",
                 i, state, MemWrite, IorD, RegWrite, exp_st[i], exp_st[i] == 5);
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    opcode = 6'b000000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'd6 || ALUOp !== 2'b10 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
      failures++;
      $display("FAIL rtex got state=%0d aluop=%b srca=%b srcb=%b exp 6 10 1 00", state, ALUOp, ALUSrcA, ALUSrcB);
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd7 || RegDst !== 1'b1 || RegWrite !== 1'b1 || MemtoReg !== 1'b0) begin
      failures++;
      $display("FAIL rtwb got state=%0d regdst=%b regwr=%b m2r=%b exp 7 1 1 0", state, RegDst, RegWrite, MemtoReg);
    end
    @(negedge clk);
    opcode = 6'b000100;
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL rtype_return got state=%0d exp=0", state);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'd8 || ALUOp !== 2'b01 || PCWriteCond !== 1'b1 || PCSource !== 2'b01 || PCWrite !== 1'b0) begin
      failures++;
      $display("FAIL beqex got state=%0d aluop=%b pcwc=%b pcsrc=%b pcw=%b exp 8 01 1 01 0",
               state, ALUOp, PCWriteCond, PCSource, PCWrite);
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL beq_return got state=%0d exp=0", state);
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    checks++;
    if (illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pre got=%b exp=0", illegal_op);
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd1 || illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL illegal_decode got state=%0d ill=%b exp 1 0", state, illegal_op);
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || illegal_op !== 1'b1) begin
      failures++;
      $display("FAIL illegal_pulse got state=%0d ill=%b exp 0 1", state, illegal_op);
    end
    opcode = 6'b001000;
    @(negedge clk);
    checks++;
    if (state !== 4'd1 || illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL illegal_clear got state=%0d ill=%b exp 1 0", state, illegal_op);
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd9 || ALUSrcB !== 2'b10 || ALUSrcA !== 1'b1) begin
      failures++;
      $display("FAIL addiex got state=%0d srcb=%b srca=%b exp 9 10 1", state, ALUSrcB, ALUSrcA);
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd10 || RegWrite !== 1'b1 || RegDst !== 1'b0 || MemtoReg !== 1'b0) begin
      failures++;
      $display("FAIL addiwb got state=%0d regwr=%b regdst=%b m2r=%b exp 10 1 0 0", state, RegWrite, RegDst, MemtoReg);
    end
    @(negedge clk);
  endtask

  task automatic test_jump();
    opcode = 6'b000010;
    @(negedge clk);
    @(negedge clk);
`ifdef MC_JUMP_EN
    checks++;
    if (state !== 4'd11 || PCWrite !== 1'b1 || PCSource !== 2'b10 || illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL jex got state=%0d pcw=%b pcsrc=%b ill=%b exp 11 1 10 0", state, PCWrite, PCSource, illegal_op);
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL jex_return got state=%0d ill=%b exp 0 0", state, illegal_op);
    end
`else
    checks++;
    if (state !== 4'd0 || illegal_op !== 1'b1) begin
      failures++;
      $display("FAIL j_illegal got state=%0d ill=%b exp 0 1", state, illegal_op);
    end
`endif
  endtask

  task automatic test_reset_mid();
    opcode = 6'b100011;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'd3) begin
      failures++;
      $display("FAIL mid_reach_memrd got state=%0d exp=3", state);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || all_outs() !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset got state=%0d outs=%h exp 0 0000", state, all_outs());
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || all_outs() !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset_hold got state=%0d outs=%h exp 0 0000", state, all_outs());
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || IRWrite !== 1'b1 || MemRead !== 1'b1) begin
      failures++;
      $display("FAIL mid_release got state=%0d ir=%b mr=%b exp 0 1 1", state, IRWrite, MemRead);
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd1) begin
      failures++;
      $display("FAIL mid_resume got state=%0d exp=1", state);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    opcode   = 6'b000000;
    test_reset();
    test_lw();
    test_sw();
    test_back_to_back();
    test_illegal();
    test_jump();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
